nvram_backup_ctrl: RTL and testbench

//  HPS-side counterpart of the 8 kB NVRAM port B: the controller that drives port B.

---
 rtl/nvram_backup_ctrl_if.sv | 35 +++
 rtl/nvram_backup_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_nvram_backup_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nvram_backup_ctrl_if.sv
// MiSTer sd_* sector interface between the NVRAM backup controller and the HPS.
// master: the controller (issues sector requests, supplies bytes to save).
// slave:  the HPS side (acknowledges sectors, streams bytes in/out).
interface nvram_backup_ctrl_if;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic        sd_buff_wr;
   logic [7:0]  sd_buff_din;

   modport master (
      output sd_lba,
      output sd_rd,
      output sd_wr,
      output sd_buff_din,
      input  sd_ack,
      input  sd_buff_addr,
      input  sd_buff_dout,
      input  sd_buff_wr
   );

   modport slave (
      input  sd_lba,
      input  sd_rd,
      input  sd_wr,
      input  sd_buff_din,
      output sd_ack,
      output sd_buff_addr,
      output sd_buff_dout,
      output sd_buff_wr
   );
endinterface

// File: rtl/nvram_backup_ctrl.sv
// NVRAM port B backup/restore controller.
// Restores the 8 kB NVRAM from the mounted save image and writes it back on an
// OSD save request or after the CPU has stopped writing NVRAM for IDLE_CYCLES.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no transfer; handles pending mount, save request, autosave
// ST_RD_REQ  | sd_rd raised for sector `block`, waiting for sd_ack rise
// ST_RD_XFER | HPS streaming sector into NVRAM, waiting for sd_ack fall
// ST_WR_REQ  | sd_wr raised for sector `block`, waiting for sd_ack rise
// ST_WR_XFER | HPS reading sector out of NVRAM, waiting for sd_ack fall
module nvram_backup_ctrl #(
   parameter int BLOCKS      = 16,
   parameter int IDLE_CYCLES = 30000000
) (
   input  logic                       clk30,
   input  logic                       reset,
   input  logic                       img_mounted,
   input  logic                       img_readonly,
   input  logic [31:0]                img_size,
   input  logic                       autosave_en,
   input  logic                       save_req,
   input  logic                       nvram_cpu_changed,
   output logic                       nvram_allow_cpu_access,
   nvram_backup_ctrl_if.master        sd,
   output logic [12:0]                nvram_backup_restore_adr,
   output logic [7:0]                 nvram_restore_data,
   output logic                       nvram_restore_write,
   input  logic [7:0]                 nvram_backup_data,
   output logic                       busy
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_REQ  = 3'd1;
   localparam logic [2:0] ST_RD_XFER = 3'd2;
   localparam logic [2:0] ST_WR_REQ  = 3'd3;
   localparam logic [2:0] ST_WR_XFER = 3'd4;

   localparam int                CNT_W     = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  IDLE_MAX  = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [3:0]        BLK_LAST  = 4'(BLOCKS - 1);
   localparam logic [31:0]       IMG_BYTES = 32'(BLOCKS * 512);

   logic [2:0]       state;
   logic [3:0]       block;
   logic [3:0]       blk_inc;
   logic             mounted;
   logic             readonly;
   logic             big_img;
   logic             pend_mount;
   logic             dirty;
   logic [CNT_W-1:0] idle_cnt;

   logic mount_evt;
   logic unmount_evt;
   logic mounted_now;
   logic idle_ok;
   logic do_restore;
   logic do_new;
   logic do_save;
   logic last_blk;

   // Decode mount events and the IDLE-state decisions for this cycle.
   // A mount pulse arriving while in IDLE defers the decision by one cycle so
   // the freshly latched size/readonly are the ones acted upon.
   always_comb begin
      mount_evt   = img_mounted && (img_size != 32'd0);
      unmount_evt = img_mounted && (img_size == 32'd0);
      mounted_now = mounted && !unmount_evt;
      idle_ok     = (state == ST_IDLE) && !img_mounted;
      do_restore  = idle_ok && pend_mount && big_img;
      do_new      = idle_ok && pend_mount && !big_img;
      do_save     = idle_ok && !pend_mount && mounted && !readonly &&
                    (save_req || (autosave_en && dirty && (idle_cnt == IDLE_MAX)));
      last_blk    = (block == BLK_LAST);
      blk_inc     = block + 4'd1;
   end

   // Sector sequencing FSM and the sd_* request handshake.
   always_ff @(posedge clk30) begin
      if (reset) begin
         state     <= ST_IDLE;
         block     <= 4'd0;
         sd.sd_rd  <= 1'b0;
         sd.sd_wr  <= 1'b0;
         sd.sd_lba <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (do_restore) begin
                  state     <= ST_RD_REQ;
                  block     <= 4'd0;
                  sd.sd_lba <= 32'd0;
                  sd.sd_rd  <= 1'b1;
               end else if (do_save) begin
                  state     <= ST_WR_REQ;
                  block     <= 4'd0;
                  sd.sd_lba <= 32'd0;
                  sd.sd_wr  <= 1'b1;
               end
            end
            ST_RD_REQ: begin
               if (sd.sd_ack) begin
                  sd.sd_rd <= 1'b0;
                  state    <= ST_RD_XFER;
               end
            end
            ST_RD_XFER: begin
               if (!sd.sd_ack) begin
                  if (last_blk || !mounted_now) begin
                     state <= ST_IDLE;
                  end else begin
                     block     <= blk_inc;
                     sd.sd_lba <= {28'd0, blk_inc};
                     sd.sd_rd  <= 1'b1;
                     state     <= ST_RD_REQ;
                  end
               end
            end
            ST_WR_REQ: begin
               if (sd.sd_ack) begin
                  sd.sd_wr <= 1'b0;
                  state    <= ST_WR_XFER;
               end
            end
            ST_WR_XFER: begin
               if (!sd.sd_ack) begin
                  if (last_blk || !mounted_now) begin
                     state <= ST_IDLE;
                  end else begin
                     block     <= blk_inc;
                     sd.sd_lba <= {28'd0, blk_inc};
                     sd.sd_wr  <= 1'b1;
                     state     <= ST_WR_REQ;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               sd.sd_rd <= 1'b0;
               sd.sd_wr <= 1'b0;
            end
         endcase
      end
   end

   // Image mount bookkeeping, dirty flag and CPU-idle counter.
   // A CPU write always re-dirties, even during a save, so the save that is
   // in flight does not hide it; an unmount discards the dirty state.
   always_ff @(posedge clk30) begin
      if (reset) begin
         mounted    <= 1'b0;
         readonly   <= 1'b0;
         big_img    <= 1'b0;
         pend_mount <= 1'b0;
         dirty      <= 1'b0;
         idle_cnt   <= '0;
      end else begin
         if (nvram_cpu_changed) begin
            idle_cnt <= '0;
         end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
         end

         if (mount_evt) begin
            mounted    <= 1'b1;
            readonly   <= img_readonly;
            big_img    <= (img_size >= IMG_BYTES);
            pend_mount <= 1'b1;
         end else if (unmount_evt) begin
            mounted    <= 1'b0;
            pend_mount <= 1'b0;
         end else if (do_restore || do_new) begin
            pend_mount <= 1'b0;
         end

         if (unmount_evt) begin
            dirty <= 1'b0;
         end else if (nvram_cpu_changed || do_new) begin
            dirty <= 1'b1;
         end else if (do_save) begin
            dirty <= 1'b0;
         end
      end
   end

   // CPU access gate lags the state by one cycle.
   always_ff @(posedge clk30) begin
      if (reset) begin
         nvram_allow_cpu_access <= 1'b1;
      end else begin
         nvram_allow_cpu_access <= !((state == ST_RD_REQ) || (state == ST_RD_XFER));
      end
   end

   // Port B data path: the HPS byte stream maps straight onto the NVRAM.
   always_comb begin
      busy                     = (state != ST_IDLE);
      nvram_backup_restore_adr = {block, sd.sd_buff_addr};
      nvram_restore_data       = sd.sd_buff_dout;
      nvram_restore_write      = sd.sd_buff_wr && (state == ST_RD_XFER);
      sd.sd_buff_din           = nvram_backup_data;
   end

endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// Bench for nvram_backup_ctrl: HPS sector model, NVRAM port-B model,
// mount table vectors, hand-written corner sequences and a randomized
// autosave-timing run checked against a gap-based reference model.
module tb_nvram_backup_ctrl;
   localparam int IDLE = 100;

   logic        clk30 = 1'b0;
   logic        reset;
   logic        img_mounted;
   logic        img_readonly;
   logic [31:0] img_size;
   logic        autosave_en;
   logic        save_req;
   logic        nvram_cpu_changed;
   logic        nvram_allow_cpu_access;
   logic [12:0] nvram_backup_restore_adr;
   logic [7:0]  nvram_restore_data;
   logic        nvram_restore_write;
   logic [7:0]  nvram_backup_data;
   logic        busy;

   nvram_backup_ctrl_if sdb();

   nvram_backup_ctrl #(.BLOCKS(16), .IDLE_CYCLES(IDLE)) dut (
      .clk30                    (clk30),
      .reset                    (reset),
      .img_mounted              (img_mounted),
      .img_readonly             (img_readonly),
      .img_size                 (img_size),
      .autosave_en              (autosave_en),
      .save_req                 (save_req),
      .nvram_cpu_changed        (nvram_cpu_changed),
      .nvram_allow_cpu_access   (nvram_allow_cpu_access),
      .sd                       (sdb),
      .nvram_backup_restore_adr (nvram_backup_restore_adr),
      .nvram_restore_data       (nvram_restore_data),
      .nvram_restore_write      (nvram_restore_write),
      .nvram_backup_data        (nvram_backup_data),
      .busy                     (busy)
   );

   always #5 clk30 = ~clk30;

   // NVRAM model: port A is the CPU, port B is the DUT with 1-cycle read latency.
   logic [7:0]  mem [0:8191];
   logic [7:0]  img [0:8191];
   logic        cpu_we;
   logic [12:0] cpu_adr;
   logic [7:0]  cpu_dat;
   int          nv_wr_cnt = 0;

   always @(posedge clk30) begin
      if (nvram_restore_write) begin
         mem[nvram_backup_restore_adr] <= nvram_restore_data;
         nv_wr_cnt <= nv_wr_cnt + 1;
      end
      if (cpu_we) mem[cpu_adr] <= cpu_dat;
      nvram_backup_data <= mem[nvram_backup_restore_adr];
   end

   int checks = 0;
   int failures = 0;
   bit rd_allow_bad;
   int inj_lba = -1;
   int inj_kind = 0;   // 1: unmount mid-sector, 2: CPU change pulse mid-sector

   typedef struct {
      logic [31:0] size;
      bit          ro;
      bit          exp_rd;
      bit          exp_wr;
   } mvec_t;
   mvec_t tv [6];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk30);
   endtask

   task automatic do_reset();
      @(negedge clk30);
      reset = 1'b1;
      @(negedge clk30);
      reset = 1'b0;
   endtask

   task automatic mount(input logic [31:0] size, input bit ro);
      @(negedge clk30);
      img_mounted  = 1'b1;
      img_size     = size;
      img_readonly = ro;
      @(negedge clk30);
      img_mounted  = 1'b0;
   endtask

   task automatic pulse_save();
      @(negedge clk30);
      save_req = 1'b1;
      @(negedge clk30);
      save_req = 1'b0;
   endtask

   // Serve one sector request; returns at the negedge where sd_ack is dropped.
   task automatic serve_sector(input int bound, output bit got, output int lba, output bit was_rd);
      int base;
      got = 1'b0;
      lba = -1;
      was_rd = 1'b0;
      for (int c = 0; c < bound && !(sdb.sd_rd || sdb.sd_wr); c++) @(negedge clk30);
      if (!(sdb.sd_rd || sdb.sd_wr)) return;
      got    = 1'b1;
      was_rd = sdb.sd_rd;
      lba    = int'(sdb.sd_lba);
      base   = (lba & 15) * 512;
      repeat ($urandom_range(0, 3)) @(negedge clk30);
      sdb.sd_ack = 1'b1;
      @(negedge clk30);
      for (int j = 0; j <= 512; j++) begin
         if (was_rd) begin
            if (nvram_allow_cpu_access) rd_allow_bad = 1'b1;
            if (j < 512) begin
               sdb.sd_buff_addr = 9'(j);
               sdb.sd_buff_dout = img[base + j];
               sdb.sd_buff_wr   = 1'b1;
            end else begin
               sdb.sd_buff_wr   = 1'b0;
            end
         end else begin
            if (j > 0) img[base + j - 1] = sdb.sd_buff_din;
            if (j < 512) sdb.sd_buff_addr = 9'(j);
         end
         if (lba == inj_lba && j == 100) begin
            if (inj_kind == 1) begin
               img_mounted = 1'b1;
               img_size    = 32'd0;
            end else if (inj_kind == 2) begin
               nvram_cpu_changed = 1'b1;
            end
         end
         if (j == 101) begin
            img_mounted       = 1'b0;
            nvram_cpu_changed = 1'b0;
         end
         @(negedge clk30);
      end
      sdb.sd_ack = 1'b0;
   endtask

   // Serve consecutive sectors; expects nexp sectors in lba order 0,1,2,...
   task automatic serve_image(input string name, input bit exp_rd, input int nexp);
      bit got;
      bit was_rd;
      int lba;
      int n = 0;
      int bad = 0;
      for (int s = 0; s < 16; s++) begin
         serve_sector(300, got, lba, was_rd);
         if (!got) break;
         if (lba != s || was_rd != exp_rd) bad++;
         n++;
      end
      chk({name, "_sectors"}, n, nexp);
      chk({name, "_lba_order"}, bad, 0);
   endtask

   function automatic int img_vs_mem();
      int m = 0;
      for (int i = 0; i < 8192; i++) if (img[i] !== mem[i]) m++;
      return m;
   endfunction

   task automatic scramble_img();
      for (int i = 0; i < 8192; i++) img[i] = 8'hA5;
   endtask

   // Counts negedges until sd_wr is seen (0 if not seen within limit).
   task automatic first_wr(input int limit, output int first);
      first = 0;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk30);
         if (sdb.sd_wr) begin
            first = k;
            break;
         end
      end
   endtask

   initial begin
      int first;
      int seen;
      int w;
      int m;
      int g;
      int lim;
      int n_short;

      reset = 1'b1; img_mounted = 1'b0; img_readonly = 1'b0; img_size = 32'd0;
      autosave_en = 1'b0; save_req = 1'b0; nvram_cpu_changed = 1'b0;
      cpu_we = 1'b0; cpu_adr = 13'd0; cpu_dat = 8'd0;
      sdb.sd_ack = 1'b0; sdb.sd_buff_addr = 9'd0; sdb.sd_buff_dout = 8'd0; sdb.sd_buff_wr = 1'b0;
      rd_allow_bad = 1'b0;

      cycles(3);
      chk("rst_sd_rd",  sdb.sd_rd, 0);
      chk("rst_sd_wr",  sdb.sd_wr, 0);
      chk("rst_sd_lba", sdb.sd_lba, 0);
      chk("rst_busy",   busy, 0);
      chk("rst_allow",  nvram_allow_cpu_access, 1);
      reset = 1'b0;

      // Mount table: size/readonly -> restore starts?, save_req accepted?
      tv[0] = '{32'd8192,       1'b0, 1'b1, 1'b0};
      tv[1] = '{32'd8191,       1'b0, 1'b0, 1'b1};
      tv[2] = '{32'h100,        1'b0, 1'b0, 1'b1};
      tv[3] = '{32'h100,        1'b1, 1'b0, 1'b0};
      tv[4] = '{32'd0,          1'b0, 1'b0, 1'b0};
      tv[5] = '{32'hFFFF_FFFF,  1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         do_reset();
         autosave_en = 1'b0;
         mount(tv[i].size, tv[i].ro);
         cycles(3);
         chk($sformatf("tv%0d_sd_rd", i), sdb.sd_rd, tv[i].exp_rd);
         chk($sformatf("tv%0d_busy", i),  busy,      tv[i].exp_rd);
         pulse_save();
         cycles(2);
         chk($sformatf("tv%0d_sd_wr", i), sdb.sd_wr, tv[i].exp_wr);
      end

      // Full restore of a known pattern.
      do_reset();
      for (int i = 0; i < 8192; i++) img[i] = 8'((((i >> 9) * 7) + (i & 511)) & 255);
      rd_allow_bad = 1'b0;
      mount(32'd8192, 1'b0);
      serve_image("t1", 1'b1, 16);
      chk("t1_allow_low_during_restore", rd_allow_bad, 0);
      cycles(2);
      chk("t1_allow_after", nvram_allow_cpu_access, 1);
      chk("t1_busy_after", busy, 0);
      m = 0;
      for (int i = 0; i < 8192; i++) if (mem[i] !== 8'((((i >> 9) * 7) + (i & 511)) & 255)) m++;
      chk("t1_nvram_content", m, 0);

      // One CPU write -> autosave exactly IDLE cycles later; re-dirty during sector 5.
      autosave_en = 1'b1;
      cycles(5);
      nvram_cpu_changed = 1'b1;
      @(negedge clk30);
      nvram_cpu_changed = 1'b0;
      first_wr(120, first);
      chk("t2_autosave_delay", first, IDLE);
      scramble_img();
      inj_lba = 5; inj_kind = 2;
      serve_image("t2", 1'b0, 16);
      inj_lba = -1; inj_kind = 0;
      chk("t2_image_eq_nvram", img_vs_mem(), 0);
      // More than IDLE cycles have passed since the mid-save write, so the
      // re-save starts on the first IDLE cycle after the save ends.
      first_wr(10, first);
      chk("t3_resave_delay", first, 2);
      scramble_img();
      serve_image("t3", 1'b0, 16);
      chk("t3_image_eq_nvram", img_vs_mem(), 0);
      first_wr(150, first);
      chk("t3_clean_after_save", first, 0);

      // Read-only small image: save requests and CPU writes never save.
      do_reset();
      autosave_en = 1'b1;
      mount(32'h100, 1'b1);
      seen = 0;
      for (int k = 0; k < 250; k++) begin
         save_req          = (k == 10);
         nvram_cpu_changed = (k == 20 || k == 40);
         @(negedge clk30);
         if (sdb.sd_wr || busy) seen++;
      end
      save_req = 1'b0; nvram_cpu_changed = 1'b0;
      chk("t4_ro_no_activity", seen, 0);

      // Unmount during sector 3 of a restore.
      do_reset();
      autosave_en = 1'b0;
      inj_lba = 3; inj_kind = 1;
      mount(32'd8192, 1'b0);
      serve_image("t5", 1'b1, 4);
      inj_lba = -1; inj_kind = 0;
      chk("t5_allow", nvram_allow_cpu_access, 1);
      chk("t5_busy", busy, 0);

      // New (small) image is dirty: autosave writes all 16 sectors, no read.
      do_reset();
      autosave_en = 1'b1;
      mount(32'h100, 1'b0);
      seen = 0;
      first = 0;
      for (int k = 1; k <= 150 && first == 0; k++) begin
         @(negedge clk30);
         if (sdb.sd_rd) seen++;
         if (sdb.sd_wr) first = k;
      end
      chk("t6_no_read", seen, 0);
      chk("t6_autosave_seen", first > 0, 1);
      scramble_img();
      serve_image("t6", 1'b0, 16);
      chk("t6_image_eq_nvram", img_vs_mem(), 0);

      // Reset while a read request is pending, then a stale ack burst.
      do_reset();
      autosave_en = 1'b0;
      mount(32'd8192, 1'b0);
      cycles(3);
      chk("t7_rd_pending", sdb.sd_rd, 1);
      reset = 1'b1;
      @(negedge clk30);
      chk("t7_rd_cleared", sdb.sd_rd, 0);
      chk("t7_busy", busy, 0);
      chk("t7_allow", nvram_allow_cpu_access, 1);
      reset = 1'b0;
      w = nv_wr_cnt;
      sdb.sd_ack = 1'b1;
      for (int j = 0; j < 5; j++) begin
         sdb.sd_buff_addr = 9'(j);
         sdb.sd_buff_dout = 8'(j + 8'h30);
         sdb.sd_buff_wr   = 1'b1;
         @(negedge clk30);
      end
      sdb.sd_buff_wr = 1'b0;
      sdb.sd_ack = 1'b0;
      cycles(3);
      chk("t7_no_nvram_write", nv_wr_cnt - w, 0);
      chk("t7_busy_after", busy, 0);

      // Randomized: random image restore, then random CPU write gaps.
      // Reference: a save starts exactly IDLE cycles after a write iff no
      // further write arrives within that window.
      do_reset();
      autosave_en = 1'b0;
      for (int i = 0; i < 8192; i++) img[i] = 8'($urandom);
      mount(32'd8192, 1'b0);
      serve_image("rnd_restore", 1'b1, 16);
      cycles(2);
      chk("rnd_restore_eq", img_vs_mem(), 0);
      autosave_en = 1'b1;
      for (int r = 0; r < 2; r++) begin
         n_short = $urandom_range(1, 4);
         for (int gi = 0; gi <= n_short; gi++) begin
            // A gap of IDLE-1 lands the next write on the save edge itself; skip it.
            g = (gi < n_short) ? $urandom_range(20, IDLE - 2) : $urandom_range(IDLE, IDLE + 40);
            lim = (g >= IDLE) ? IDLE : g;
            cpu_we = 1'b1;
            cpu_adr = 13'($urandom);
            cpu_dat = 8'($urandom);
            nvram_cpu_changed = 1'b1;
            @(negedge clk30);
            cpu_we = 1'b0;
            nvram_cpu_changed = 1'b0;
            first_wr(lim, first);
            chk($sformatf("rnd%0d_gap%0d_g%0d", r, gi, g), first, (g >= IDLE) ? IDLE : 0);
            if (first != 0 && g < IDLE) break;
         end
         scramble_img();
         serve_image($sformatf("rnd%0d_save", r), 1'b0, 16);
         chk($sformatf("rnd%0d_image_eq", r), img_vs_mem(), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
